// File: rtl/axi_reg_pkg.sv
// Shared AXI encodings and FSM state types for the AXI register slave.
package axi_reg_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_reg_addr_gen.sv
// Beat address generator: yields the address of the beat about to become current
// (the start address on an address handshake, else the advanced address) with its
// register index and an error flag covering range, burst type and transfer size.
module axi_reg_addr_gen
  import axi_reg_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int STRB_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [1:0]        burst,
  input  logic [2:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              err
);

  localparam int         LSB       = $clog2(STRB_W);
  localparam logic [2:0] FULL_SIZE = 3'(LSB);

  logic burst_ok;

  always_comb begin
    burst_ok = (burst == BURST_FIXED) || (burst == BURST_INCR);
    // Increment wraps naturally at 2^ADDR_W; bad bursts hold the address.
    if (start)
      addr = start_addr;
    else if (burst == BURST_INCR)
      addr = cur_addr + ADDR_W'(STRB_W);
    else
      addr = cur_addr;
    idx = addr[LSB +: IDX_W];
    err = (|addr[ADDR_W-1:LSB+IDX_W]) || !burst_ok || (size != FULL_SIZE);
  end

endmodule

// File: rtl/axi_reg_slave.sv
// AXI4 full-width register bank slave with independent write and read FSMs.
// Optional AXI_REG_SLAVE_WSTRB_EN enables byte-strobe merging on writes.
module axi_reg_slave
  import axi_reg_pkg::*;
#(
  parameter int  AXI_ADDR_WIDTH   = 32,
  parameter int  AXI_DATA_WIDTH   = 128,
  parameter int  NUM_REGS         = 16,
  localparam int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                               s_axi_aclk,
  input  logic                               s_axi_areset,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [15:0]                        s_axi_awid,
  input  logic [1:0]                         s_axi_awburst,
  input  logic [2:0]                         s_axi_awsize,
  input  logic [7:0]                         s_axi_awlen,
  input  logic                               s_axi_awvalid,
  output logic                               s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [AXI_STROBE_WIDTH-1:0]        s_axi_wstrb,
  input  logic                               s_axi_wvalid,
  input  logic                               s_axi_wlast,
  output logic                               s_axi_wready,
  output logic [15:0]                        s_axi_bid,
  output logic [1:0]                         s_axi_bresp,
  output logic                               s_axi_bvalid,
  input  logic                               s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [15:0]                        s_axi_arid,
  input  logic [1:0]                         s_axi_arburst,
  input  logic [2:0]                         s_axi_arsize,
  input  logic [7:0]                         s_axi_arlen,
  input  logic                               s_axi_arvalid,
  output logic                               s_axi_arready,
  output logic [15:0]                        s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                         s_axi_rresp,
  output logic                               s_axi_rlast,
  output logic                               s_axi_rvalid,
  input  logic                               s_axi_rready,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                reg_wr
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                      init_done;

  w_state_e w_state, w_state_nxt;
  r_state_e r_state, r_state_nxt;

  logic aw_hs, w_hs, ar_hs, r_hs;

  // Write channel context; w_bad flags the current beat as not writable.
  logic [AXI_ADDR_WIDTH-1:0] w_addr, wg_addr;
  logic [IDX_W-1:0]          w_idx, wg_idx;
  logic                      w_bad, wg_err;
  logic [1:0]                w_burst;
  logic [2:0]                w_size;
  logic [7:0]                w_len;
  logic [8:0]                w_cnt;
  logic                      w_err, len_err, wr_en;
  logic [15:0]               bid_q;
  logic [1:0]                bresp_q;
  logic [AXI_DATA_WIDTH-1:0] wr_word;

  logic [AXI_ADDR_WIDTH-1:0] r_addr, rg_addr;
  logic [IDX_W-1:0]          rg_idx;
  logic                      rg_err;
  logic [1:0]                r_burst;
  logic [2:0]                r_size;
  logic [7:0]                r_len, r_cnt;
  logic [15:0]               rid_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                rresp_q;
  logic                      rlast_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign r_hs  = s_axi_rvalid & s_axi_rready;

  // Holds the address-channel readies low until the first edge after reset release.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) init_done <= 1'b0;
    else              init_done <= 1'b1;
  end

  axi_reg_addr_gen #(
    .ADDR_W   (AXI_ADDR_WIDTH),
    .STRB_W   (AXI_STROBE_WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_waddr (
    .start      (aw_hs),
    .start_addr (s_axi_awaddr),
    .cur_addr   (w_addr),
    .burst      ((w_state == W_IDLE) ? s_axi_awburst : w_burst),
    .size       ((w_state == W_IDLE) ? s_axi_awsize : w_size),
    .addr       (wg_addr),
    .idx        (wg_idx),
    .err        (wg_err)
  );

  axi_reg_addr_gen #(
    .ADDR_W   (AXI_ADDR_WIDTH),
    .STRB_W   (AXI_STROBE_WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_raddr (
    .start      (ar_hs),
    .start_addr (s_axi_araddr),
    .cur_addr   (r_addr),
    .burst      ((r_state == R_IDLE) ? s_axi_arburst : r_burst),
    .size       ((r_state == R_IDLE) ? s_axi_arsize : r_size),
    .addr       (rg_addr),
    .idx        (rg_idx),
    .err        (rg_err)
  );

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) w_state <= W_IDLE;
    else              w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && s_axi_wlast) w_state_nxt = W_RESP;
      W_RESP:  if (s_axi_bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = init_done && (w_state == W_IDLE);
    s_axi_wready  = (w_state == W_DATA);
    s_axi_bvalid  = (w_state == W_RESP);
  end

  // A beat is a length error if wlast disagrees with reaching beat awlen.
  assign len_err = s_axi_wlast != (w_cnt == {1'b0, w_len});
  assign wr_en   = w_hs && !w_bad;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_addr  <= '0;
      w_idx   <= '0;
      w_bad   <= 1'b0;
      w_burst <= '0;
      w_size  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bid_q   <= '0;
      bresp_q <= RESP_OKAY;
    end else if (aw_hs) begin
      w_addr  <= wg_addr;
      w_idx   <= wg_idx;
      w_bad   <= wg_err;
      w_burst <= s_axi_awburst;
      w_size  <= s_axi_awsize;
      w_len   <= s_axi_awlen;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bid_q   <= s_axi_awid;
    end else if (w_hs) begin
      w_addr <= wg_addr;
      w_idx  <= wg_idx;
      w_bad  <= wg_err;
      w_cnt  <= w_cnt + 9'd1;
      w_err  <= w_err | w_bad | len_err;
      if (s_axi_wlast)
        bresp_q <= (w_err | w_bad | len_err) ? RESP_SLVERR : RESP_OKAY;
    end
  end

`ifdef AXI_REG_SLAVE_WSTRB_EN
  always_comb begin
    wr_word = regs[w_idx];
    for (int b = 0; b < AXI_STROBE_WIDTH; b++)
      if (s_axi_wstrb[b]) wr_word[8*b +: 8] = s_axi_wdata[8*b +: 8];
  end
`else
  logic wstrb_unused;
  assign wstrb_unused = ^s_axi_wstrb;
  assign wr_word      = s_axi_wdata;
`endif

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[w_idx] <= wr_word;
    end
  end

  always_comb begin
    reg_wr = '0;
    if (wr_en) reg_wr[w_idx] = 1'b1;
    for (int i = 0; i < NUM_REGS; i++)
      reg_q[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[i];
  end

  assign s_axi_bid   = bid_q;
  assign s_axi_bresp = bresp_q;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) r_state <= R_IDLE;
    else              r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = init_done && (r_state == R_IDLE);
    s_axi_rvalid  = (r_state == R_DATA);
  end

  // Read data is captured when a beat becomes current, so it stays stable
  // through rready stalls and a same-edge write yields the old value.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_addr  <= '0;
      r_burst <= '0;
      r_size  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      rid_q   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
    end else if (ar_hs) begin
      r_addr  <= rg_addr;
      r_burst <= s_axi_arburst;
      r_size  <= s_axi_arsize;
      r_len   <= s_axi_arlen;
      r_cnt   <= '0;
      rid_q   <= s_axi_arid;
      rdata_q <= rg_err ? '0 : regs[rg_idx];
      rresp_q <= rg_err ? RESP_SLVERR : RESP_OKAY;
      rlast_q <= (s_axi_arlen == 8'd0);
    end else if (r_hs && !rlast_q) begin
      r_addr  <= rg_addr;
      r_cnt   <= r_cnt + 8'd1;
      rdata_q <= rg_err ? '0 : regs[rg_idx];
      rresp_q <= rg_err ? RESP_SLVERR : RESP_OKAY;
      rlast_q <= ((r_cnt + 8'd1) == r_len);
    end
  end

  assign s_axi_rid   = rid_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_rlast = rlast_q;

endmodule

// File: tb/tb_axi_reg_slave.sv
// Scoreboard bench for axi_reg_slave: directed AXI transactions push expected
// B/R responses; a negedge monitor compares whatever the DUT presents.
module tb_axi_reg_slave;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int NR = 16;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   awaddr, araddr;
  logic [15:0]     awid, arid, bid, rid;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic [2:0]      awsize, arsize;
  logic [7:0]      awlen, arlen;
  logic            awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0]   wdata, rdata;
  logic [SW-1:0]   wstrb;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]   reg_wr;

  always #5 clk = ~clk;

  axi_reg_slave #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awid(awid), .s_axi_awburst(awburst),
    .s_axi_awsize(awsize), .s_axi_awlen(awlen), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
    .s_axi_wlast(wlast), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arid(arid), .s_axi_arburst(arburst),
    .s_axi_arsize(arsize), .s_axi_arlen(arlen), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  typedef struct packed { logic [15:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [15:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t        b_q[$];
  r_exp_t        r_q[$];
  logic [DW-1:0] exp_reg [NR];
  logic [DW-1:0] wbuf [8];
  int            wr_cnt [NR];
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      4: return rvalid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input string name);
    int t = 0;
    while (!sig(w) && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout_%s: got 0 want 1", name);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = nw;
`ifdef AXI_REG_SLAVE_WSTRB_EN
    r = old;
    for (int b = 0; b < SW; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
`endif
    return r;
  endfunction

  // Response monitor: compares the head entry every cycle a response is valid,
  // and retires it on the handshake.
  always @(negedge clk) begin
    if (bvalid) begin
      if (b_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_unexpected: got bid %h want none", bid);
      end else begin
        check("bid", DW'(bid), DW'(b_q[0].id));
        check("bresp", DW'(bresp), DW'(b_q[0].resp));
        if (bready) void'(b_q.pop_front());
      end
    end
    if (rvalid) begin
      if (r_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL r_unexpected: got rid %h want none", rid);
      end else begin
        check("rid", DW'(rid), DW'(r_q[0].id));
        check("rdata", rdata, r_q[0].data);
        check("rresp", DW'(rresp), DW'(r_q[0].resp));
        check("rlast", DW'(rlast), DW'(r_q[0].last));
        if (rready) void'(r_q.pop_front());
      end
    end
    for (int i = 0; i < NR; i++)
      if (reg_wr[i]) wr_cnt[i]++;
  end

  task automatic clr_cnt();
    for (int i = 0; i < NR; i++) wr_cnt[i] = 0;
  endtask

  function automatic int total_wr();
    int s = 0;
    for (int i = 0; i < NR; i++) s += wr_cnt[i];
    return s;
  endfunction

  task automatic check_regs();
    for (int i = 0; i < NR; i++)
      check($sformatf("reg%0d", i), reg_q[i*DW +: DW], exp_reg[i]);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [15:0] id, input logic [1:0] burst,
                          input logic [2:0] size, input logic [7:0] len, input int nbeats,
                          input logic [SW-1:0] strb, input int bdelay,
                          input logic [1:0] exp_resp, input logic bad);
    logic [AW-1:0] a;
    b_exp_t e;
    e.id = id; e.resp = exp_resp;
    b_q.push_back(e);
    awaddr = addr; awid = id; awburst = burst; awsize = size; awlen = len; awvalid = 1'b1;
    wait_for(0, "aw");
    tick();
    awvalid = 1'b0;
    a = addr;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
      wait_for(1, "w");
      tick();
      if (!bad && a < 32'h100) exp_reg[a[7:4]] = merge(exp_reg[a[7:4]], wbuf[i], strb);
      if (burst == 2'b01) a = a + 32'd16;
    end
    wvalid = 1'b0; wlast = 1'b0;
    wait_for(2, "b");
    repeat (bdelay) tick();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [15:0] id, input logic [1:0] burst,
                         input logic [2:0] size, input logic [7:0] len, input int rdelay,
                         input logic bad);
    logic [AW-1:0] a;
    r_exp_t e;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.last = (i == int'(len));
      if (bad || a >= 32'h100) begin
        e.data = '0; e.resp = 2'b10;
      end else begin
        e.data = exp_reg[a[7:4]]; e.resp = 2'b00;
      end
      r_q.push_back(e);
      if (burst == 2'b01) a = a + 32'd16;
    end
    araddr = addr; arid = id; arburst = burst; arsize = size; arlen = len; arvalid = 1'b1;
    wait_for(3, "ar");
    tick();
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wait_for(4, "r");
      repeat (rdelay) tick();
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; awid = '0; awburst = '0; awsize = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    araddr = '0; arid = '0; arburst = '0; arsize = '0; arlen = '0; arvalid = 1'b0;
    rready = 1'b0;
    for (int i = 0; i < NR; i++) exp_reg[i] = '0;
    clr_cnt();

    // Reset state
    repeat (3) tick();
    check("awready_in_reset", DW'(awready), DW'(0));
    rst = 1'b0;
    check("awready_pre_edge", DW'(awready), DW'(0));
    tick();
    check("awready_post", DW'(awready), DW'(1));
    check("arready_post", DW'(arready), DW'(1));
    check("wready_post", DW'(wready), DW'(0));
    check("bvalid_post", DW'(bvalid), DW'(0));
    check("rvalid_post", DW'(rvalid), DW'(0));
    check_regs();

    // Single write to reg 1
    clr_cnt();
    wbuf[0] = {16{8'hA5}};
    do_write(32'h10, 16'h1234, 2'b01, 3'd4, 8'd0, 1, 16'hFFFF, 0, 2'b00, 1'b0);
    check("single_reg1", reg_q[1*DW +: DW], {16{8'hA5}});
    check("single_wr1", DW'(wr_cnt[1]), DW'(1));
    check("single_wr_total", DW'(total_wr()), DW'(1));
    check_regs();

    // INCR 4-beat write then read back
    clr_cnt();
    wbuf[0] = 128'h000102030405060708090A0B0C0D0E0F;
    wbuf[1] = 128'h11111111222222223333333344444444;
    wbuf[2] = 128'hCAFEBABEDEADBEEF0123456789ABCDEF;
    wbuf[3] = 128'hFFFFFFFF00000000FFFFFFFF00000001;
    do_write(32'h0, 16'h0042, 2'b01, 3'd4, 8'd3, 4, 16'hFFFF, 0, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("incr_wr%0d", i), DW'(wr_cnt[i]), DW'(1));
    check("incr_wr_total", DW'(total_wr()), DW'(4));
    check_regs();
    do_read(32'h0, 16'h0077, 2'b01, 3'd4, 8'd3, 0, 1'b0);

    // FIXED burst: three beats land on reg 2
    clr_cnt();
    wbuf[0] = {8{16'h1357}}; wbuf[1] = {8{16'h2468}}; wbuf[2] = {4{32'h0BADF00D}};
    do_write(32'h20, 16'h0005, 2'b00, 3'd4, 8'd2, 3, 16'hFFFF, 0, 2'b00, 1'b0);
    check("fixed_reg2", reg_q[2*DW +: DW], {4{32'h0BADF00D}});
    check("fixed_wr2", DW'(wr_cnt[2]), DW'(3));
    check_regs();

    // Out of range write and read
    clr_cnt();
    wbuf[0] = {16{8'h5A}};
    do_write(32'h100, 16'h0100, 2'b01, 3'd4, 8'd0, 1, 16'hFFFF, 0, 2'b10, 1'b0);
    check("oob_wr_total", DW'(total_wr()), DW'(0));
    check_regs();
    do_read(32'h100, 16'h0101, 2'b01, 3'd4, 8'd0, 0, 1'b0);

    // Burst crossing the top of the register window
    clr_cnt();
    wbuf[0] = {16{8'h3C}}; wbuf[1] = {16{8'hC3}};
    do_write(32'hF0, 16'h00F0, 2'b01, 3'd4, 8'd1, 2, 16'hFFFF, 0, 2'b10, 1'b0);
    check("cross_wr15", DW'(wr_cnt[15]), DW'(1));
    check("cross_wr_total", DW'(total_wr()), DW'(1));
    check_regs();
    do_read(32'hF0, 16'h00F1, 2'b01, 3'd4, 8'd1, 0, 1'b0);

    // WRAP burst rejected, bad size rejected, short burst flagged
    clr_cnt();
    wbuf[0] = {4{32'hDEADDEAD}};
    do_write(32'h30, 16'h0003, 2'b10, 3'd4, 8'd0, 1, 16'hFFFF, 0, 2'b10, 1'b1);
    check("wrap_wr_total", DW'(total_wr()), DW'(0));
    wbuf[0] = '0;
    do_write(32'h90, 16'h0009, 2'b01, 3'd3, 8'd0, 1, 16'hFFFF, 0, 2'b10, 1'b1);
    wbuf[0] = {16{8'h66}}; wbuf[1] = {16{8'h77}};
    do_write(32'h50, 16'h0050, 2'b01, 3'd4, 8'd3, 2, 16'hFFFF, 0, 2'b10, 1'b0);
    check_regs();
    do_read(32'h00, 16'h0002, 2'b01, 3'd2, 8'd0, 0, 1'b1);

    // Strobes, with a stalled B channel
    wbuf[0] = {16{8'h11}};
    do_write(32'h40, 16'h0004, 2'b01, 3'd4, 8'd0, 1, 16'hFFFF, 0, 2'b00, 1'b0);
    wbuf[0] = {16{8'hEE}};
    do_write(32'h40, 16'h0044, 2'b01, 3'd4, 8'd0, 1, 16'h000F, 3, 2'b00, 1'b0);
`ifdef AXI_REG_SLAVE_WSTRB_EN
    check("strb_reg4", reg_q[4*DW +: DW], {{12{8'h11}}, {4{8'hEE}}});
`else
    check("strb_reg4", reg_q[4*DW +: DW], {16{8'hEE}});
`endif
    check_regs();

    // Read with a stalled R channel, then a 256-beat FIXED read
    do_read(32'h0, 16'h0A0A, 2'b01, 3'd4, 8'd3, 5, 1'b0);
    do_read(32'h20, 16'h0B0B, 2'b00, 3'd4, 8'd255, 0, 1'b0);

    // Reset in the middle of an 8-beat burst
    wbuf[0] = {16{8'h81}}; wbuf[1] = {16{8'h92}}; wbuf[2] = {16{8'hA3}};
    awaddr = 32'h80; awid = 16'h0808; awburst = 2'b01; awsize = 3'd4; awlen = 8'd7; awvalid = 1'b1;
    wait_for(0, "aw_rst");
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wdata = wbuf[i]; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
      wait_for(1, "w_rst");
      tick();
      exp_reg[8 + i] = wbuf[i];
    end
    check_regs();
    #2 rst = 1'b1;
    #1;
    wvalid = 1'b0;
    for (int i = 0; i < NR; i++) exp_reg[i] = '0;
    check("rst_wready", DW'(wready), DW'(0));
    check("rst_bvalid", DW'(bvalid), DW'(0));
    check("rst_awready", DW'(awready), DW'(0));
    check_regs();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_awready_after", DW'(awready), DW'(1));
    check("rst_arready_after", DW'(arready), DW'(1));
    for (int i = 0; i < 5; i++) begin
      check("rst_no_bvalid", DW'(bvalid), DW'(0));
      tick();
    end
    do_read(32'h80, 16'h0C0C, 2'b01, 3'd4, 8'd0, 0, 1'b0);

    repeat (3) tick();
    check("b_queue_empty", DW'(b_q.size()), DW'(0));
    check("r_queue_empty", DW'(r_q.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_reg_slave.md
AXI_REG_SLAVE -- requirements
Module: axi_reg_slave

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 128, data width; AXI_STROBE_WIDTH = AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_REGS, default 16, power of two, number of AXI_DATA_WIDTH-bit registers.
REQ-004 SHALL have ports, in order: s_axi_aclk in 1 clock; s_axi_areset in 1 reset, asynchronous, active-high.
REQ-005 SHALL have AW ports: s_axi_awaddr in AXI_ADDR_WIDTH; s_axi_awid in 16; s_axi_awburst in 2; s_axi_awsize in 3; s_axi_awlen in 8; s_axi_awvalid in 1; s_axi_awready out 1.
REQ-006 SHALL have W ports: s_axi_wdata in AXI_DATA_WIDTH; s_axi_wstrb in AXI_STROBE_WIDTH; s_axi_wvalid in 1; s_axi_wlast in 1; s_axi_wready out 1.
REQ-007 SHALL have B ports: s_axi_bid out 16; s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
REQ-008 SHALL have AR ports: s_axi_araddr in AXI_ADDR_WIDTH; s_axi_arid in 16; s_axi_arburst in 2; s_axi_arsize in 3; s_axi_arlen in 8; s_axi_arvalid in 1; s_axi_arready out 1.
REQ-009 SHALL have R ports: s_axi_rid out 16; s_axi_rdata out AXI_DATA_WIDTH; s_axi_rresp out 2; s_axi_rlast out 1; s_axi_rvalid out 1; s_axi_rready in 1.
REQ-010 SHALL have user ports: reg_q out NUM_REGS*AXI_DATA_WIDTH, flattened register contents, reg 0 at LSBs; reg_wr out NUM_REGS, one-cycle pulse per register written.

Function
REQ-011 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; AW handshake captures awid/awaddr/awburst/awlen, -> W_DATA.
REQ-012 In W_DATA wready SHALL be 1; each wvalid&wready beat updates the addressed register on the next edge and pulses its reg_wr bit that same cycle.
REQ-013 Beat address SHALL be +AXI_STROBE_WIDTH per beat for INCR (2'b01), constant for FIXED (2'b00); word index = addr[$clog2(AXI_STROBE_WIDTH) +: $clog2(NUM_REGS)].
REQ-014 Beat with wlast SHALL move to W_RESP; bvalid held with bid=captured awid until bready, then -> W_IDLE.
REQ-015 bresp SHALL be SLVERR (2'b10) if any beat address >= NUM_REGS*AXI_STROBE_WIDTH, awburst is WRAP/reserved, awsize != $clog2(AXI_STROBE_WIDTH), or wlast beat count != awlen+1; otherwise OKAY; out-of-range or bad-burst beats SHALL NOT modify registers.
REQ-016 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE; AR handshake captures arid/araddr/arburst/arlen, -> R_DATA.
REQ-017 In R_DATA rvalid SHALL be 1 with rdata from current beat address, rid=arid, rlast=1 on beat arlen; rdata/rresp/rlast stable while rvalid&!rready; last beat handshake -> R_IDLE.
REQ-018 Read beats out of range or with bad burst/size SHALL return rdata=0, rresp=SLVERR; others OKAY.
REQ-019 Read and write FSMs SHALL run independently; same-cycle read and write to one register returns pre-write value.
REQ-020 Address increment SHALL wrap modulo 2^AXI_ADDR_WIDTH; awlen=255 (256 beats) SHALL be supported.

Reset
REQ-021 s_axi_areset SHALL asynchronously force both FSMs to IDLE, all registers to 0, all outputs to 0 except awready=1 and arready=1 after first clock edge with reset low.
REQ-022 Reset mid-burst SHALL abandon the burst with no response issued.

Configuration
REQ-023 With AXI_REG_SLAVE_WSTRB_EN defined, only bytes with wstrb[i]=1 SHALL be written; without it, wstrb SHALL be ignored and full words written.

Structure
REQ-024 Package axi_reg_pkg SHALL hold burst/resp localparams (BURST_FIXED, BURST_INCR, RESP_OKAY, RESP_SLVERR) and the write/read FSM state enums.
REQ-025 Sub-module axi_reg_addr_gen SHALL compute next beat address and range/error flag, instantiated once per channel.

Verification
REQ-026 Single write addr 0x10 data 0xA5..A5, awlen 0 -> reg 1 = data, reg_wr[1] one pulse, bresp OKAY, bid=awid.
REQ-027 INCR write addr 0x0 awlen 3 -> regs 0..3 written, one B; INCR read same -> 4 beats, rlast on 4th only, data match.
REQ-028 Write addr 0x100 (NUM_REGS=16) -> bresp SLVERR, no register change; read addr 0x100 -> rdata 0, rresp SLVERR.
REQ-029 Read with rready low 5 cycles per beat and bready low 3 cycles -> outputs stable, no beat lost or duplicated.
REQ-030 wstrb=0x000F with macro defined -> only bytes 0..3 change; without macro -> whole word; reset asserted mid 8-beat burst -> FSMs IDLE, regs 0, no bvalid.
